// File: rtl/alu_pkg.sv
// Op-code encoding and shared constants for the execute-stage ALU.
package alu_pkg;

  localparam int OP_W       = 5;
  localparam int ALU_OP_MAX = 10;

  typedef enum logic [OP_W-1:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_LUI  = 5'd10
  } alu_op_e;

endpackage

// File: rtl/ALU.sv
// Combinational execute-stage ALU; unknown op-codes fall back to add and raise o_illegal.
module ALU
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);

  logic signed [XLEN-1:0] w_a_s;
  logic signed [XLEN-1:0] w_b_s;
  logic        [4:0]      w_shamt;

  assign w_a_s   = i_a;
  assign w_b_s   = i_b;
  assign w_shamt = i_b[4:0];

  always_comb begin
    o_result  = i_a + i_b;
    o_illegal = (int'(i_op) > ALU_OP_MAX);
    case (i_op)
      ALU_SUB:  o_result = i_a - i_b;
      ALU_SLL:  o_result = i_a << w_shamt;
      ALU_SLT:  o_result = XLEN'(w_a_s < w_b_s);
      ALU_SLTU: o_result = XLEN'(i_a < i_b);
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SRL:  o_result = i_a >> w_shamt;
      ALU_SRA:  o_result = w_a_s >>> w_shamt;
      ALU_OR:   o_result = i_a | i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_LUI:  o_result = i_b;
      default:  o_result = i_a + i_b;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters, with a single
// registered response slot that can drain and refill in the same cycle.
module alu_share_arbiter
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32,
  parameter int OP_W    = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ*OP_W-1:0] req_op_i,
  input  logic [NUM_REQ*XLEN-1:0] req_a_i,
  input  logic [NUM_REQ*XLEN-1:0] req_b_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic                    rsp_valid_o,
  output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id_o,
  output logic [XLEN-1:0]         rsp_result_o,
  output logic                    rsp_illegal_o,
  input  logic                    rsp_ready_i
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Returns {found, winner}: rotate so rr_ptr is bit 0, take the lowest set bit, map back.
  function automatic logic [ID_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                            input logic [ID_W-1:0]    ptr);
    logic [ID_W:0] pick;
    pick = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (vld[(int'(ptr) + k) % NUM_REQ]) begin
        pick = {1'b1, ID_W'((int'(ptr) + k) % NUM_REQ)};
      end
    end
    return pick;
  endfunction

  logic [ID_W-1:0] r_rr_ptr;
  logic            r_rsp_valid;
  logic [ID_W-1:0] r_rsp_id;
  logic [XLEN-1:0] r_rsp_result;
  logic            r_rsp_illegal;

  logic            w_can_accept;
  logic [ID_W:0]   w_pick;
  logic [ID_W-1:0] w_gnt_id;
  logic            w_xfer;
  logic [OP_W-1:0] w_op;
  logic [XLEN-1:0] w_a;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_alu_illegal;

  assign w_can_accept = !r_rsp_valid | rsp_ready_i;
  assign w_pick       = rr_pick(req_valid_i, r_rr_ptr);
  assign w_gnt_id     = w_pick[ID_W-1:0];
  assign w_xfer       = w_can_accept & w_pick[ID_W] & !rst;
  assign req_ready_o  = w_xfer ? (NUM_REQ'(1) << w_gnt_id) : '0;

  assign w_op = req_op_i[int'(w_gnt_id)*OP_W +: OP_W];
  assign w_a  = req_a_i[int'(w_gnt_id)*XLEN +: XLEN];
  assign w_b  = req_b_i[int'(w_gnt_id)*XLEN +: XLEN];

  ALU #(.XLEN(XLEN)) u_alu (
    .i_op      (w_op),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_result  (w_alu_result),
    .o_illegal (w_alu_illegal)
  );

  // Response slot: load on transfer, otherwise drain when the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr      <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_result  <= '0;
      r_rsp_illegal <= 1'b0;
    end else if (w_xfer) begin
      r_rr_ptr      <= ID_W'((int'(w_gnt_id) + 1) % NUM_REQ);
      r_rsp_valid   <= 1'b1;
      r_rsp_id      <= w_gnt_id;
      r_rsp_result  <= w_alu_result;
      r_rsp_illegal <= w_alu_illegal;
    end else if (rsp_ready_i) begin
      r_rsp_valid   <= 1'b0;
    end
  end

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_id_o      = r_rsp_id;
  assign rsp_result_o  = r_rsp_result;
  assign rsp_illegal_o = r_rsp_illegal;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed and randomized bench for alu_share_arbiter against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int N = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid_i;
  logic [N*5-1:0]  req_op_i;
  logic [N*32-1:0] req_a_i;
  logic [N*32-1:0] req_b_i;
  logic [N-1:0]    req_ready_o;
  logic            rsp_valid_o;
  logic [0:0]      rsp_id_o;
  logic [31:0]     rsp_result_o;
  logic            rsp_illegal_o;
  logic            rsp_ready_i;

  alu_share_arbiter #(.NUM_REQ(N), .XLEN(32), .OP_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid_i   (req_valid_i),
    .req_op_i      (req_op_i),
    .req_a_i       (req_a_i),
    .req_b_i       (req_b_i),
    .req_ready_o   (req_ready_o),
    .rsp_valid_o   (rsp_valid_o),
    .rsp_id_o      (rsp_id_o),
    .rsp_result_o  (rsp_result_o),
    .rsp_illegal_o (rsp_illegal_o),
    .rsp_ready_i   (rsp_ready_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [4:0]  t_op [N];
  logic [31:0] t_a  [N];
  logic [31:0] t_b  [N];

  // Transaction-level model state
  int          m_valid, m_id, m_ptr;
  logic [31:0] m_res;
  logic        m_ill;
  int          last_gnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, output logic ill);
    int     sh;
    longint sa, sb, p;
    sh  = int'(b % 32);
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    p   = 64'sd1 << sh;
    ill = 1'b0;
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return 32'(longint'({32'h0, a}) * p);
      3:  return (sa < sb) ? 32'd1 : 32'd0;
      4:  return ({32'h0, a} < {32'h0, b}) ? 32'd1 : 32'd0;
      5:  return a ^ b;
      6:  return 32'(longint'({32'h0, a}) / p);
      7:  return (sa < 0) ? 32'((sa - p + 1) / p) : 32'(sa / p);
      8:  return a | b;
      9:  return a & b;
      10: return b;
      default: begin
        ill = 1'b1;
        return a + b;
      end
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_ptr = 0; m_res = '0; m_ill = 1'b0;
  endtask

  // One clock cycle: drive at negedge, check grant, take edge, check response slot.
  task automatic cycle(input logic [N-1:0] vld, input logic rr);
    logic [31:0] r;
    logic        il;
    int          g;
    req_valid_i = vld;
    rsp_ready_i = rr;
    for (int i = 0; i < N; i++) begin
      req_op_i[i*5 +: 5]  = t_op[i];
      req_a_i[i*32 +: 32] = t_a[i];
      req_b_i[i*32 +: 32] = t_b[i];
    end
    #1;
    g = -1;
    if (m_valid == 0 || rr) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && vld[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    chk("req_ready", 64'(req_ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge clk);
    if (g >= 0) begin
      r = ref_alu(int'(t_op[g]), t_a[g], t_b[g], il);
      m_valid = 1; m_id = g; m_res = r; m_ill = il; m_ptr = (g + 1) % N;
    end else if (rr) begin
      m_valid = 0;
    end
    last_gnt = g;
    #1;
    chk("rsp_valid",   64'(rsp_valid_o),   64'(m_valid));
    chk("rsp_id",      64'(rsp_id_o),      64'(m_id));
    chk("rsp_result",  64'(rsp_result_o),  64'(m_res));
    chk("rsp_illegal", 64'(rsp_illegal_o), 64'(m_ill));
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    t_op[i] = op; t_a[i] = a; t_b[i] = b;
  endtask

  logic [31:0] hold_res;
  logic [0:0]  hold_id;

  initial begin
    rst = 1'b1;
    req_valid_i = '1; req_op_i = '0; req_a_i = '0; req_b_i = '0; rsp_ready_i = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 5'd0, 32'd0, 32'd0);
    model_reset();
    #2;
    chk("reset_ready",  64'(req_ready_o),  64'd0);
    chk("reset_valid",  64'(rsp_valid_o),  64'd0);
    chk("reset_id",     64'(rsp_id_o),     64'd0);
    chk("reset_result", 64'(rsp_result_o), 64'd0);
    chk("reset_ill",    64'(rsp_illegal_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Single request on requester 0
    set_req(0, 5'd0, 32'd7, 32'd5);
    cycle(2'b01, 1'b1);
    chk("add_result", 64'(rsp_result_o), 64'd12);
    chk("add_id",     64'(rsp_id_o),     64'd0);

    // Both requesters continuously valid: grants alternate
    set_req(0, 5'd1, 32'd0, 32'd1);
    set_req(1, 5'd1, 32'd0, 32'd1);
    for (int c = 0; c < 4; c++) begin
      cycle(2'b11, 1'b1);
      chk("alt_gnt", 64'(rsp_id_o), 64'((c + 1) % 2));
      chk("sub_result", 64'(rsp_result_o), 64'hFFFF_FFFF);
    end

    // Backpressure: slot held, no grants, then same-cycle regrant
    hold_res = rsp_result_o;
    hold_id  = rsp_id_o;
    for (int c = 0; c < 3; c++) begin
      cycle(2'b11, 1'b0);
      chk("bp_ready",  64'(req_ready_o),  64'd0);
      chk("bp_result", 64'(rsp_result_o), 64'(hold_res));
      chk("bp_id",     64'(rsp_id_o),     64'(hold_id));
    end
    cycle(2'b11, 1'b1);
    chk("bp_regrant", 64'(last_gnt >= 0), 64'd1);

    // Shift and compare corner cases
    set_req(0, 5'd7, 32'h8000_0000, 32'h0000_0024);
    cycle(2'b01, 1'b1);
    chk("sra", 64'(rsp_result_o), 64'hF800_0000);
    set_req(0, 5'd3, 32'hFFFF_FFFF, 32'd1);
    cycle(2'b01, 1'b1);
    chk("slt", 64'(rsp_result_o), 64'd1);
    set_req(0, 5'd4, 32'hFFFF_FFFF, 32'd1);
    cycle(2'b01, 1'b1);
    chk("sltu", 64'(rsp_result_o), 64'd0);

    // Illegal op-code falls back to add
    set_req(0, 5'b11111, 32'd3, 32'd4);
    cycle(2'b01, 1'b1);
    chk("ill_result", 64'(rsp_result_o),  64'd7);
    chk("ill_flag",   64'(rsp_illegal_o), 64'd1);

    // Reset asserted while a response is pending
    set_req(1, 5'd0, 32'd1, 32'd1);
    cycle(2'b10, 1'b0);
    chk("pre_rst_valid", 64'(rsp_valid_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_ready",       64'(req_ready_o), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle(2'b11, 1'b1);
    chk("post_rst_first", 64'(last_gnt), 64'd0);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) set_req(i, 5'($urandom_range(0, 12)), $urandom, $urandom);
      cycle(N'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
